// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and helpers for the memory access stage:
//   - funct3_e    : load/store size and signedness encoding
//   - mem_state_e : stage FSM states
//   - LANES       : byte lanes per data-cache doubleword
//   - align_mask  : low address bits that must be zero for a natural access
//   - lane_strobe : unshifted byte-enable pattern for an access size
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int LANES = 8;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RESP,
        ST_DONE
    } mem_state_e;

    // Size lives in funct3[1:0]; the sign bit funct3[2] does not affect alignment.
    function automatic logic [2:0] align_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [LANES-1:0] lane_strobe(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/load_aligner.sv
// -----------------------------------------------------------------------------
// load_aligner
// Combinational extraction of a load result from an aligned doubleword.
// Ports:
//   i_rdata  [63:0] doubleword returned by the data cache
//   i_off    [2:0]  byte offset of the access inside the doubleword
//   i_funct3 [2:0]  size/sign selector (funct3_e)
//   o_result [63:0] selected bytes, sign- or zero-extended to 64 bits
// -----------------------------------------------------------------------------
module load_aligner
    import mem_stage_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_result
);

    logic [63:0] w_shifted;

    // Bring the addressed byte down to lane 0; upper lanes are then trimmed.
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_result = w_shifted;
        case (i_funct3)
            F3_B:    o_result = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_H:    o_result = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_result = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_BU:   o_result = {56'd0, w_shifted[7:0]};
            F3_HU:   o_result = {48'd0, w_shifted[15:0]};
            F3_WU:   o_result = {32'd0, w_shifted[31:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// Pipeline stage after execute. Performs RV64 loads/stores against the data
// cache over a valid/ready request and a response strobe, and passes
// non-memory results straight to writeback one cycle later.
//
// Ports:
//   clk, reset (async, active-low)
//   memory_enable                 start strobe, honoured only when idle
//   alu_data_in / store_data_in   effective address or result / store data
//   mem_read, mem_write           load / store (both high -> load)
//   mem_funct3                    size/sign (funct3_e)
//   rd_in, reg_write_in           destination register info
//   dcache_req_valid/ready        request handshake
//   dcache_addr, dcache_we        byte address and write enable
//   dcache_wdata, dcache_wstrb    lane-shifted store data and byte enables
//   dcache_resp_valid/rdata       load response (aligned doubleword)
//   wb_data_out, wb_rd_out,
//   wb_reg_write_out              writeback payload, valid with memory_done
//   memory_done                   one-cycle completion pulse
//   mem_busy                      high whenever the FSM is not idle
//   misaligned_fault              valid with memory_done
//
// Build option: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned accesses complete immediately with a fault and
//               never reach the cache
//   undefined - the address is forced down to natural alignment and the
//               access proceeds; misaligned_fault stays 0
// -----------------------------------------------------------------------------
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_enable,
    input  logic [DATA_W-1:0] alu_data_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_funct3,
    input  logic [4:0]        rd_in,
    input  logic              reg_write_in,
    output logic              dcache_req_valid,
    input  logic              dcache_req_ready,
    output logic [ADDR_W-1:0] dcache_addr,
    output logic              dcache_we,
    output logic [DATA_W-1:0] dcache_wdata,
    output logic [LANES-1:0]  dcache_wstrb,
    input  logic              dcache_resp_valid,
    input  logic [DATA_W-1:0] dcache_rdata,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [4:0]        wb_rd_out,
    output logic              wb_reg_write_out,
    output logic              memory_done,
    output logic              mem_busy,
    output logic              misaligned_fault
);

    mem_state_e r_state;
    mem_state_e w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [LANES-1:0]  r_wstrb;
    logic              r_is_load;
    logic [2:0]        r_funct3;
    logic [DATA_W-1:0] r_wb_data;
    logic [4:0]        r_wb_rd;
    logic              r_wb_reg_write;

    logic              w_capture;
    logic              w_resp_take;
    logic              w_mem_op;
    logic              w_is_load;
    logic              w_is_store;
    logic [2:0]        w_mask;
    logic              w_misaligned;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_off;
    logic [DATA_W-1:0] w_load_result;

    assign w_capture   = (r_state == ST_IDLE) && memory_enable;
    assign w_resp_take = (r_state == ST_WAIT_RESP) && dcache_resp_valid;

    // Both strobes high is treated as a load.
    assign w_mem_op   = mem_read | mem_write;
    assign w_is_load  = mem_read;
    assign w_is_store = mem_write & ~mem_read;
    assign w_mask     = align_mask(mem_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_fault;

    assign w_misaligned = w_mem_op && ((alu_data_in[2:0] & w_mask) != 3'b000);
    assign w_addr       = alu_data_in[ADDR_W-1:0];
`else
    assign w_misaligned = 1'b0;
    // Drop the sub-size address bits so the access is always natural.
    assign w_addr       = {alu_data_in[ADDR_W-1:3], alu_data_in[2:0] & ~w_mask};
`endif

    assign w_off = w_addr[2:0];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: each signal written here gets a default first, so no branch
        // leaves it unassigned and no latch is inferred.
        w_state_next     = r_state;
        dcache_req_valid = 1'b0;
        memory_done      = 1'b0;
        mem_busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (memory_enable) begin
                    if (!w_mem_op || w_misaligned) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                dcache_req_valid = 1'b1;
                if (dcache_req_ready) begin
                    w_state_next = r_is_load ? ST_WAIT_RESP : ST_DONE;
                end
            end
            ST_WAIT_RESP: begin
                if (dcache_resp_valid) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                memory_done  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: everything is captured at start and held, so the cache sees a
    // stable request for as long as ready stays low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_is_load      <= 1'b0;
            r_funct3       <= 3'b000;
            r_wb_data      <= '0;
            r_wb_rd        <= 5'd0;
            r_wb_reg_write <= 1'b0;
        end else if (w_capture) begin
            r_addr         <= w_addr;
            r_wdata        <= store_data_in << {w_off, 3'b000};
            r_wstrb        <= lane_strobe(mem_funct3) << w_off;
            r_is_load      <= w_is_load;
            r_funct3       <= mem_funct3;
            r_wb_data      <= alu_data_in;
            r_wb_rd        <= rd_in;
            r_wb_reg_write <= reg_write_in && !w_is_store && !w_misaligned;
        end else if (w_resp_take) begin
            r_wb_data      <= w_load_result;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fault <= 1'b0;
        end else if (w_capture) begin
            r_fault <= w_misaligned;
        end
    end

    assign misaligned_fault = memory_done & r_fault;
`else
    assign misaligned_fault = 1'b0;
`endif

    load_aligner u_load_aligner (
        .i_rdata  (dcache_rdata),
        .i_off    (r_addr[2:0]),
        .i_funct3 (r_funct3),
        .o_result (w_load_result)
    );

    // Request fields are driven only while the request is live.
    assign dcache_addr  = dcache_req_valid ? r_addr : '0;
    assign dcache_we    = dcache_req_valid & ~r_is_load;
    assign dcache_wdata = dcache_req_valid ? r_wdata : '0;
    assign dcache_wstrb = dcache_req_valid ? r_wstrb : '0;

    assign wb_data_out      = r_wb_data;
    assign wb_rd_out        = r_wb_rd;
    assign wb_reg_write_out = r_wb_reg_write;

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
// Directed and randomized transactions against a transaction-level model of
// the memory access stage. A cache responder process answers requests with
// programmable ready/response delays and injects stray response strobes; a
// monitor compares every cycle against the model's expectations.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memory_enable = 1'b0;
    logic [63:0] alu_data_in = '0;
    logic [63:0] store_data_in = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_funct3 = 3'b000;
    logic [4:0]  rd_in = 5'd0;
    logic        reg_write_in = 1'b0;
    logic        dcache_req_valid;
    logic        dcache_req_ready = 1'b0;
    logic [63:0] dcache_addr;
    logic        dcache_we;
    logic [63:0] dcache_wdata;
    logic [7:0]  dcache_wstrb;
    logic        dcache_resp_valid = 1'b0;
    logic [63:0] dcache_rdata = '0;
    logic [63:0] wb_data_out;
    logic [4:0]  wb_rd_out;
    logic        wb_reg_write_out;
    logic        memory_done;
    logic        mem_busy;
    logic        misaligned_fault;

    memory_access_stage dut (
        .clk               (clk),
        .reset             (reset),
        .memory_enable     (memory_enable),
        .alu_data_in       (alu_data_in),
        .store_data_in     (store_data_in),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_funct3        (mem_funct3),
        .rd_in             (rd_in),
        .reg_write_in      (reg_write_in),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_ready  (dcache_req_ready),
        .dcache_addr       (dcache_addr),
        .dcache_we         (dcache_we),
        .dcache_wdata      (dcache_wdata),
        .dcache_wstrb      (dcache_wstrb),
        .dcache_resp_valid (dcache_resp_valid),
        .dcache_rdata      (dcache_rdata),
        .wb_data_out       (wb_data_out),
        .wb_rd_out         (wb_rd_out),
        .wb_reg_write_out  (wb_reg_write_out),
        .memory_done       (memory_done),
        .mem_busy          (mem_busy),
        .misaligned_fault  (misaligned_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------------
    typedef struct {
        bit          req;
        bit          we;
        bit          is_load;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        bit          chk_data;
        logic [63:0] data;
        logic [4:0]  rd;
        bit          rw;
        bit          fault;
        int          lat;
    } exp_t;

    exp_t ex;

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010, 3'b110: return 4;
            default:        return 8;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off, input logic [2:0] f3);
        int          n;
        logic [63:0] v;
        logic [63:0] mask;
        n    = size_of(f3);
        v    = rdata >> (8 * off);
        mask = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
        v    = v & mask;
        if (f3 < 3'd4 && n < 8 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic exp_t build_exp(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                                       input logic [63:0] addr, input logic [63:0] sdata,
                                       input logic [4:0] rd, input bit rw, input int rdy,
                                       input int rsp, input logic [63:0] rdata);
        exp_t        e;
        int          n;
        int          off;
        bit          mem;
        bit          store;
        logic [63:0] eff;
        n     = size_of(f3);
        mem   = rd_op || wr_op;
        store = wr_op && !rd_op;
`ifdef MEM_MISALIGN_TRAP_EN
        e.fault = mem && ((addr % 64'(n)) != 64'd0);
        eff     = addr;
`else
        e.fault = 1'b0;
        eff     = addr - (addr % 64'(n));
`endif
        off       = int'(eff % 64'd8);
        e.req     = mem && !e.fault;
        e.we      = store;
        e.is_load = rd_op && e.req;
        e.addr    = eff;
        e.wdata   = sdata << (8 * off);
        e.wstrb   = 8'(((1 << n) - 1) << off);
        if (!mem) begin
            e.chk_data = 1'b1;
            e.data     = addr;
        end else if (e.is_load) begin
            e.chk_data = 1'b1;
            e.data     = model_load(rdata, off, f3);
        end else begin
            e.chk_data = 1'b0;
            e.data     = '0;
        end
        e.rd = rd;
        e.rw = rw && !store && !e.fault;
        if (!e.req)      e.lat = 1;
        else if (store)  e.lat = 2 + rdy;
        else             e.lat = 3 + rdy + rsp;
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Cache responder
    // ------------------------------------------------------------------------
    int          rdy_dly = 0;
    int          rsp_dly = 0;
    logic [63:0] rsp_data = '0;
    bit          load_pending = 1'b0;
    bit          spurious_en = 1'b0;
    int          stall_cnt = 0;
    int          wait_cnt = 0;

    always @(negedge clk) begin
        dcache_resp_valid = 1'b0;
        if (load_pending) begin
            if (wait_cnt >= rsp_dly) begin
                dcache_resp_valid = 1'b1;
                dcache_rdata      = rsp_data;
                load_pending      = 1'b0;
            end else begin
                wait_cnt++;
                dcache_rdata = rand64();
            end
        end else if (spurious_en && $urandom_range(0, 3) == 0) begin
            dcache_resp_valid = 1'b1;
            dcache_rdata      = rand64();
        end
        if (dcache_req_valid) begin
            if (stall_cnt < rdy_dly) begin
                dcache_req_ready = 1'b0;
                stall_cnt++;
            end else begin
                dcache_req_ready = 1'b1;
                load_pending     = ex.is_load;
                wait_cnt         = 0;
            end
        end else begin
            dcache_req_ready = 1'($urandom);
        end
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    bit          txn_active = 1'b0;
    bit          quiet = 1'b1;
    int          req_cycles = 0;
    logic [63:0] last_req_addr = '0;
    logic [63:0] last_wdata = '0;
    logic [7:0]  last_wstrb = '0;

    always @(negedge clk) begin
        if (!reset || quiet) begin
            check("quiet_busy",         mem_busy, 0);
            check("quiet_done",         memory_done, 0);
            check("quiet_req_valid",    dcache_req_valid, 0);
            check("quiet_dcache_addr",  dcache_addr, 0);
            check("quiet_dcache_we",    dcache_we, 0);
            check("quiet_dcache_wdata", dcache_wdata, 0);
            check("quiet_dcache_wstrb", dcache_wstrb, 0);
            check("quiet_wb_data",      wb_data_out, 0);
            check("quiet_wb_rd",        wb_rd_out, 0);
            check("quiet_wb_reg_write", wb_reg_write_out, 0);
            check("quiet_fault",        misaligned_fault, 0);
        end else begin
            check("mem_busy",   mem_busy, txn_active);
            check("req_gate",   dcache_req_valid && !(txn_active && ex.req), 0);
            check("done_gate",  memory_done && !txn_active, 0);
            check("fault_gate", misaligned_fault && !memory_done, 0);
            if (dcache_req_valid && txn_active && ex.req) begin
                req_cycles++;
                last_req_addr = dcache_addr;
                last_wdata    = dcache_wdata;
                last_wstrb    = dcache_wstrb;
                check("req_addr", dcache_addr, ex.addr);
                check("req_we",   dcache_we, ex.we);
                if (ex.we) begin
                    check("req_wdata", dcache_wdata, ex.wdata);
                    check("req_wstrb", dcache_wstrb, ex.wstrb);
                end
            end
            if (memory_done && txn_active) begin
                check("wb_rd",        wb_rd_out, ex.rd);
                check("wb_reg_write", wb_reg_write_out, ex.rw);
                check("fault",        misaligned_fault, ex.fault);
                if (ex.chk_data) check("wb_data", wb_data_out, ex.data);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    logic [63:0] got_data = '0;
    logic        got_fault = 1'b0;
    logic        got_rw = 1'b0;
    int          got_lat = 0;

    task automatic run_txn(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] sdata,
                           input logic [4:0] rd, input bit rw, input int rdy,
                           input int rsp, input logic [63:0] rdata, input bit poke);
        int lat;
        @(posedge clk); #1;
        ex         = build_exp(rd_op, wr_op, f3, addr, sdata, rd, rw, rdy, rsp, rdata);
        rdy_dly    = rdy;
        rsp_dly    = rsp;
        rsp_data   = rdata;
        stall_cnt  = 0;
        req_cycles = 0;
        memory_enable = 1'b1;
        alu_data_in   = addr;
        store_data_in = sdata;
        mem_read      = rd_op;
        mem_write     = wr_op;
        mem_funct3    = f3;
        rd_in         = rd;
        reg_write_in  = rw;
        @(posedge clk); #1;
        txn_active    = 1'b1;
        // Optional enable pulse while busy, carrying junk that must be ignored.
        memory_enable = poke;
        alu_data_in   = rand64();
        store_data_in = rand64();
        mem_read      = 1'($urandom);
        mem_write     = 1'($urandom);
        mem_funct3    = 3'($urandom);
        rd_in         = 5'($urandom);
        reg_write_in  = 1'($urandom);
        lat = 1;
        while (!memory_done && lat < 64) begin
            @(posedge clk); #1;
            memory_enable = 1'b0;
            lat++;
        end
        got_data  = wb_data_out;
        got_fault = misaligned_fault;
        got_rw    = wb_reg_write_out;
        got_lat   = lat;
        check("done_seen", memory_done, 1);
        check("latency", lat, ex.lat);
        @(posedge clk); #1;
        memory_enable = 1'b0;
        txn_active    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r;
        bit          w;
        int          kind;
        logic [2:0]  f3;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 quiet = 1'b0;
        spurious_en = 1'b1;

        // ALU pass-through
        run_txn(0, 0, 3'b000, 64'h1234, 64'h0, 5'd5, 1, 0, 0, 64'h0, 0);
        check("alu_data", got_data, 64'h1234);
        check("alu_latency", got_lat, 1);
        check("alu_reg_write", got_rw, 1);
        check("alu_no_req", req_cycles, 0);

        // LB / LBU of a byte with the top bit set
        run_txn(1, 0, 3'b000, 64'h1003, 64'h0, 5'd7, 1, 0, 0, 64'h0000_0000_8000_0000, 0);
        check("lb_data", got_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_latency", got_lat, 3);
        run_txn(1, 0, 3'b100, 64'h1003, 64'h0, 5'd7, 1, 0, 0, 64'h0000_0000_8000_0000, 0);
        check("lbu_data", got_data, 64'h80);

        // SH with ready held low for three cycles
        run_txn(0, 1, 3'b001, 64'h1002, 64'hABCD, 5'd9, 1, 3, 0, 64'h0, 0);
        check("sh_valid_cycles", req_cycles, 4);
        check("sh_wstrb", last_wstrb, 8'h0C);
        check("sh_wdata", last_wdata, 64'hABCD_0000);
        check("sh_latency", got_lat, 5);
        check("sh_reg_write", got_rw, 0);

        // LD at a doubleword-misaligned address
        run_txn(1, 0, 3'b011, 64'h1004, 64'h0, 5'd3, 1, 0, 1, 64'h1122_3344_5566_7788, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("ld_mis_fault", got_fault, 1);
        check("ld_mis_latency", got_lat, 1);
        check("ld_mis_no_req", req_cycles, 0);
        check("ld_mis_reg_write", got_rw, 0);
`else
        check("ld_mis_addr", last_req_addr, 64'h1000);
        check("ld_mis_data", got_data, 64'h1122_3344_5566_7788);
        check("ld_mis_fault", got_fault, 0);
`endif

        // LW with an enable pulse while busy
        run_txn(1, 0, 3'b010, 64'h200C, 64'h0, 5'd12, 1, 1, 2, 64'hDEAD_BEEF_8765_4321, 1);
        check("lw_poke_data", got_data, 64'hFFFF_FFFF_DEAD_BEEF);
        check("lw_poke_latency", got_lat, 6);

        // Reset while waiting for a load response; response arrives afterwards
        @(posedge clk); #1;
        ex         = build_exp(1, 0, 3'b011, 64'h3000, 64'h0, 5'd4, 1, 0, 8, 64'h5555_AAAA_5555_AAAA);
        rdy_dly    = 0;
        rsp_dly    = 8;
        rsp_data   = 64'h5555_AAAA_5555_AAAA;
        stall_cnt  = 0;
        memory_enable = 1'b1;
        alu_data_in   = 64'h3000;
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        mem_funct3    = 3'b011;
        rd_in         = 5'd4;
        reg_write_in  = 1'b1;
        @(posedge clk); #1;
        memory_enable = 1'b0;
        txn_active    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        quiet      = 1'b1;
        txn_active = 1'b0;
        reset      = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (12) @(posedge clk);
        #1 quiet = 1'b0;

        // Randomized traffic
        repeat (200) begin
            kind = $urandom_range(0, 3);
            r    = (kind == 1) || (kind == 3);
            w    = (kind == 2) || (kind == 3);
            if (w && !r)  f3 = 3'($urandom_range(0, 3));
            else if (r)   f3 = 3'($urandom_range(0, 6));
            else          f3 = 3'($urandom);
            run_txn(r, w, f3, rand64(), rand64(), 5'($urandom), 1'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), rand64(),
                    $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
